trig_capture: RTL and testbench

- Parametrised ADC trace-capture engine; successor to the single-channel fixed-160-sample buffer filler.
- Watches a synchronous ADC sample stream and detects a programmable level crossing with selectable slope.
- Writes DEPTH decimated samples into the display sample RAM through a simple write port.
- Supports normal, auto (free-run on timeout) and single-shot modes, with a frame-ack handshake to the VGA reader.
- Sits between the ADC interface (already synchronised to clk) and the display RAM.

---
 rtl/trig_capture.sv | 240 ++++++++++++++++++++++++
 tb/tb_trig_capture.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_capture.sv
`default_nettype none
// ============================================================================
//  Module      : trig_capture
//  Description : ADC trace-capture engine. Watches a synchronous sample
//                stream for a programmable level crossing (rising or
//                falling), then writes DEPTH decimated samples into the
//                display sample RAM. Supports normal, auto (free-run on
//                timeout) and single-shot modes with a frame-ack handshake
//                from the display reader.
//  Ports       :
//      clk           system clock
//      reset         synchronous active-high reset
//      sample_valid  one-cycle strobe, adc_data valid this cycle
//      adc_data      unsigned ADC sample
//      trig_level    trigger threshold (unsigned compare)
//      trig_slope    0 = rising, 1 = falling
//      mode          0 normal, 1 auto, 2 single, 3 normal
//      decim         keep 1 of every decim+1 valid samples while capturing
//      arm           level, starts a capture from IDLE/DONE
//      frame_ack     one-cycle pulse, display consumed the frame
//      wr_en         RAM write strobe
//      wr_addr       RAM write address
//      wr_data       RAM write data
//      busy          high while ARMED or CAPTURE
//      done          one-cycle pulse after the last write of a frame
//      triggered     last frame started on a real trigger (0 = auto timeout)
//  Revision    : 1.0  initial release
// ============================================================================
module trig_capture #(
    parameter int DATA_W  = 14,
    parameter int DEPTH   = 160,
    parameter int ADDR_W  = 8,
    parameter int DECIM_W = 8,
    parameter int AUTO_TO = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  adc_data,
    input  logic [DATA_W-1:0]  trig_level,
    input  logic               trig_slope,
    input  logic [1:0]         mode,
    input  logic [DECIM_W-1:0] decim,
    input  logic               arm,
    input  logic               frame_ack,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               busy,
    output logic               done,
    output logic               triggered
);

    // Frame index must be able to hold DEPTH itself: reaching DEPTH marks
    // the frame as full and blocks further writes.
    localparam int IDX_W = $clog2(DEPTH + 1);
    localparam int TO_W  = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;

    localparam logic [IDX_W-1:0] c_full_idx = IDX_W'(DEPTH);
    localparam logic [TO_W-1:0]  c_to_last  = TO_W'(AUTO_TO - 1);

    localparam logic [1:0] c_mode_auto   = 2'd1;
    localparam logic [1:0] c_mode_single = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic               r_above_prev;
    logic               r_above_prev_valid;
    logic [TO_W-1:0]    r_to_cnt;
    logic [DECIM_W-1:0] r_dec_cnt;
    logic [DECIM_W-1:0] r_decim;
    logic [IDX_W-1:0]   r_idx;

    logic               w_above;
    logic               w_rise;
    logic               w_fall;
    logic               w_edge;
    logic               w_full;
    logic               w_start;
    logic               w_trig_hit;
    logic               w_keep;
    logic               w_enter_armed;
    logic [IDX_W-1:0]   w_idx_cur;

    // ------------------------------------------------------------------
    // Level comparator and edge detection. above_prev_valid is cleared on
    // every entry into ARMED so the first sample after arming can only
    // seed the history, never fire a trigger.
    // ------------------------------------------------------------------
    assign w_above = (adc_data >= trig_level);
    assign w_rise  =  w_above & ~r_above_prev & r_above_prev_valid;
    assign w_fall  = ~w_above &  r_above_prev & r_above_prev_valid;
    assign w_edge  = trig_slope ? w_fall : w_rise;

    assign w_full  = (r_idx == c_full_idx);

    // The frame-start sample always lands at address 0, even though r_idx
    // still holds the count from the previous frame at that moment.
    assign w_idx_cur = w_start ? '0 : r_idx;

    assign busy = (r_state == S_ARMED) || (r_state == S_CAPTURE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and per-cycle control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_trig_hit    = 1'b0;
        w_keep        = 1'b0;
        w_enter_armed = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_nxt   = S_ARMED;
                    w_enter_armed = 1'b1;
                end
            end

            S_ARMED: begin
                if (sample_valid) begin
                    // A real edge wins over a coincident timeout.
                    if (w_edge) begin
                        w_start     = 1'b1;
                        w_trig_hit  = 1'b1;
                        w_keep      = 1'b1;
                        w_state_nxt = S_CAPTURE;
                    end else if ((mode == c_mode_auto) && (r_to_cnt == c_to_last)) begin
                        w_start     = 1'b1;
                        w_keep      = 1'b1;
                        w_state_nxt = S_CAPTURE;
                    end
                end
            end

            S_CAPTURE: begin
                if (sample_valid && (r_dec_cnt == '0) && !w_full) begin
                    w_keep = 1'b1;
                end
                // r_idx hits DEPTH in the cycle the last write is on the
                // port; leave next edge so done follows that write.
                if (w_full) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                if (mode == c_mode_single) begin
                    if (arm) begin
                        w_state_nxt   = S_ARMED;
                        w_enter_armed = 1'b1;
                    end
                end else if (arm || frame_ack) begin
                    w_state_nxt   = S_ARMED;
                    w_enter_armed = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: trigger history, counters and the registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en              <= 1'b0;
            wr_addr            <= '0;
            wr_data            <= '0;
            done               <= 1'b0;
            triggered          <= 1'b0;
            r_above_prev       <= 1'b0;
            r_above_prev_valid <= 1'b0;
            r_to_cnt           <= '0;
            r_dec_cnt          <= '0;
            r_decim            <= '0;
            r_idx              <= '0;
        end else begin
            wr_en <= w_keep;
            done  <= (r_state == S_CAPTURE) && w_full;

            // Address and data hold their last values between writes.
            if (w_keep) begin
                wr_data <= adc_data;
                wr_addr <= ADDR_W'(w_idx_cur);
                r_idx   <= w_idx_cur + IDX_W'(1);
            end

            if (sample_valid) begin
                r_above_prev <= w_above;
            end

            if (w_enter_armed) begin
                r_above_prev_valid <= 1'b0;
                r_to_cnt           <= '0;
            end else if ((r_state == S_ARMED) && sample_valid) begin
                r_above_prev_valid <= 1'b1;
                // Never increments past c_to_last: that sample starts a frame.
                if ((mode == c_mode_auto) && !w_start) begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end

            // decim is latched at frame start so mid-frame changes are
            // ignored; the start sample is counted as position 0.
            if (w_start) begin
                triggered <= w_trig_hit;
                r_decim   <= decim;
                r_dec_cnt <= (decim == '0) ? '0 : DECIM_W'(1);
            end else if ((r_state == S_CAPTURE) && sample_valid) begin
                r_dec_cnt <= (r_dec_cnt == r_decim) ? '0 : r_dec_cnt + DECIM_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trig_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_trig_capture
//  Description : Directed self-checking bench for trig_capture. A negedge
//                monitor logs every RAM write and done pulse; each scenario
//                compares the log against hand-computed frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trig_capture;

    localparam int DATA_W  = 14;
    localparam int DEPTH   = 160;
    localparam int ADDR_W  = 8;
    localparam int DECIM_W = 8;
    localparam int AUTO_TO = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sample_valid = 1'b0;
    logic [DATA_W-1:0]  adc_data = '0;
    logic [DATA_W-1:0]  trig_level = '0;
    logic               trig_slope = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic [DECIM_W-1:0] decim = '0;
    logic               arm = 1'b0;
    logic               frame_ack = 1'b0;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               busy;
    logic               done;
    logic               triggered;

    trig_capture #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .DECIM_W (DECIM_W),
        .AUTO_TO (AUTO_TO)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .adc_data     (adc_data),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .mode         (mode),
        .decim        (decim),
        .arm          (arm),
        .frame_ack    (frame_ack),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .triggered    (triggered)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Monitor: cycle counter plus write / done log
    // ------------------------------------------------------------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned log_addr [0:4095];
    int unsigned log_data [0:4095];
    int          log_cyc  [0:4095];
    int          wr_total = 0;
    int          done_total = 0;
    int          last_done_cyc = -1;

    always @(negedge clk) begin
        if (wr_en && (wr_total < 4096)) begin
            log_addr[wr_total] <= 32'(wr_addr);
            log_data[wr_total] <= 32'(wr_data);
            log_cyc[wr_total]  <= cyc;
            wr_total           <= wr_total + 1;
        end
        if (done) begin
            done_total    <= done_total + 1;
            last_done_cyc <= cyc;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int d);
        sample_valid = 1'b1;
        adc_data     = DATA_W'(d);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        idle(1);
        frame_ack = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        idle(1);
        arm = 1'b0;
    endtask

    // Frame written since log index `base`: DEPTH writes, addresses 0..DEPTH-1,
    // data = first + i*dstep, write i lands i*spacing cycles after write 0,
    // and exactly one done pulse one cycle after the last write.
    task automatic frame_check(input string tag, input int base, input int done_base,
                               input int first, input int dstep, input int spacing);
        int n;
        int bad_a;
        int bad_d;
        int bad_c;
        n     = wr_total - base;
        bad_a = 0;
        bad_d = 0;
        bad_c = 0;
        check({tag, " write count"}, n, DEPTH);
        for (int i = 0; i < n && i < DEPTH; i++) begin
            if (log_addr[base+i] != i) bad_a++;
            if (log_data[base+i] != first + i*dstep) bad_d++;
            if (log_cyc[base+i] - log_cyc[base] != i*spacing) bad_c++;
        end
        if (n > 0) begin
            check({tag, " first data"}, log_data[base], first);
            check({tag, " done cycle"}, last_done_cyc, log_cyc[base+n-1] + 1);
        end
        check({tag, " addr seq errs"}, bad_a, 0);
        check({tag, " data errs"}, bad_d, 0);
        check({tag, " spacing errs"}, bad_c, 0);
        check({tag, " done pulses"}, done_total - done_base, 1);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    initial begin
        int base;
        int dbase;

        idle(3);
        check("reset wr_en", wr_en, 0);
        check("reset outputs", {wr_addr, wr_data, busy, done, triggered}, 0);
        reset = 1'b0;
        idle(2);
        check("idle busy", busy, 0);

        // ---- Rising trigger ------------------------------------------
        mode = 2'd0; trig_level = 14'd8192; trig_slope = 1'b0; decim = '0;
        pulse_arm();
        check("armed busy", busy, 1);
        base = wr_total; dbase = done_total;
        send(8000);
        send(8100);
        for (int i = 0; i < DEPTH; i++) send(8200 + i);
        idle(3);
        frame_check("rise", base, dbase, 8200, 1, 1);
        check("rise triggered", triggered, 1);
        check("rise busy after", busy, 0);
        check("rise wr_en low", wr_en, 0);
        check("rise addr held", wr_addr, DEPTH - 1);

        // ---- Falling slope, first sample cannot trigger -------------
        // Last sample of the previous frame was above 100, so 50 would be
        // a falling edge if history were not invalidated on arming.
        trig_slope = 1'b1; trig_level = 14'd100;
        pulse_ack();
        base = wr_total; dbase = done_total;
        send(50);
        idle(1);
        check("fall first no trig", wr_total - base, 0);
        check("fall still armed", busy, 1);
        send(150);
        for (int i = 0; i < DEPTH; i++) send(90 + i);
        idle(3);
        frame_check("fall", base, dbase, 90, 1, 1);
        check("fall triggered", triggered, 1);

        // ---- Decimation by 3; mid-frame decim change ignored --------
        trig_slope = 1'b0; trig_level = 14'd8192; decim = 8'd2;
        pulse_ack();
        base = wr_total; dbase = done_total;
        send(0);
        send(9000);
        decim = 8'd0;
        for (int k = 1; k <= 480; k++) send(9000 + k);
        idle(3);
        frame_check("decim", base, dbase, 9000, 3, 3);

        // ---- Auto timeout --------------------------------------------
        mode = 2'd1;
        pulse_ack();
        base = wr_total; dbase = done_total;
        for (int i = 0; i < AUTO_TO - 1; i++) send(0);
        idle(1);
        check("auto no early write", wr_total - base, 0);
        send(0);
        check("auto start wr_en", wr_en, 1);
        check("auto start addr", wr_addr, 0);
        check("auto triggered", triggered, 0);
        for (int i = 1; i < DEPTH; i++) send(0);
        idle(1);
        check("auto done pulse", done, 1);
        // frame_ack in the same cycle as done re-arms.
        pulse_ack();
        check("auto ack on done", busy, 1);
        frame_check("auto", base, dbase, 0, 0, 1);

        base = wr_total; dbase = done_total;
        send(0);
        send(0);
        send(9000);
        check("auto real edge trig", triggered, 1);
        for (int i = 1; i < DEPTH; i++) send(9000 + i);
        idle(3);
        frame_check("auto edge", base, dbase, 9000, 1, 1);

        // ---- Single mode ---------------------------------------------
        mode = 2'd2;
        pulse_ack();
        idle(2);
        check("single ack ignored", busy, 0);
        pulse_arm();
        check("single arm", busy, 1);
        base = wr_total; dbase = done_total;
        send(0);
        for (int i = 0; i < DEPTH; i++) send(9000 + i);
        idle(3);
        frame_check("single", base, dbase, 9000, 1, 1);
        pulse_ack();
        idle(1);
        check("single stays done", busy, 0);

        // ---- Reset mid-capture ---------------------------------------
        mode = 2'd0;
        pulse_arm();
        dbase = done_total;
        send(0);
        for (int k = 0; k <= 80; k++) send(9000 + k);
        check("pre-reset addr", wr_addr, 80);
        reset = 1'b1;
        send(9081);
        check("rst wr_en", wr_en, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        base = wr_total;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) send(9100 + k);
        idle(3);
        check("rst no writes", wr_total - base, 0);
        check("rst no done", done_total - dbase, 0);
        check("rst idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
